// File: rtl/multiples_sweep_checker.sv
// Sweeps in_o over 0..15, holding each value for SETTLE_CYCLES cycles before checking three detector outputs against the prime set.
// One vector every SETTLE_CYCLES+1 cycles, with no backpressure. Define SWEEP_ERRCOUNT_EN to count every mismatch instead of stopping at the first one.
module multiples_sweep_checker #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [3:0] in_o,
   input  logic       out_g,
   input  logic       out_d,
   input  logic       out_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [4:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] settle_cnt;
   logic       expected;
   logic       mismatch;
   logic       launch;

   function automatic logic golden(input logic [3:0] v);
      case (v)
         4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: golden = 1'b1;
         default:                               golden = 1'b0;
      endcase
   endfunction

   assign expected = golden(in_o);
   // All three detectors must agree with the golden value; any split vote fails.
   assign mismatch = expected ? !(out_g && out_d && out_b) : (out_g || out_d || out_b);
   assign launch   = start && (state == IDLE || state == DONE);

   assign busy = (state == SETTLE) || (state == CHECK);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_o       <= 4'd0;
         settle_cnt <= 4'd0;
         pass       <= 1'b0;
         fail_vec   <= 4'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= SETTLE;
                  in_o       <= 4'd0;
                  settle_cnt <= 4'd0;
                  pass       <= 1'b1;
                  fail_vec   <= 4'd0;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= CHECK;
                  settle_cnt <= 4'd0;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            CHECK: begin
               if (mismatch && pass) begin
                  pass     <= 1'b0;
                  fail_vec <= in_o;
               end
`ifdef SWEEP_ERRCOUNT_EN
               if (in_o == 4'd15) begin
`else
               if (mismatch || in_o == 4'd15) begin
`endif
                  state <= DONE;
               end else begin
                  in_o  <= in_o + 4'd1;
                  state <= SETTLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SWEEP_ERRCOUNT_EN
   logic [4:0] err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 5'd0;
      end else if (launch) begin
         err_q <= 5'd0;
      end else if (state == CHECK && mismatch) begin
         err_q <= err_q + 5'd1;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 5'd0;
`endif

endmodule

// File: tb/tb_multiples_sweep_checker.sv
// Directed bench for multiples_sweep_checker: table of detector fault modes plus reset/start corner sequences.
module tb_multiples_sweep_checker;

   localparam int S     = 4;
   localparam int SWEEP = 16 * (S + 1);

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] in_o;
   logic       out_g, out_d, out_b;
   logic       busy, done, pass;
   logic [3:0] fail_vec;
   logic [4:0] err_cnt;

   int mode;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multiples_sweep_checker #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .start(start), .in_o(in_o),
      .out_g(out_g), .out_d(out_d), .out_b(out_b),
      .busy(busy), .done(done), .pass(pass),
      .fail_vec(fail_vec), .err_cnt(err_cnt)
   );

   function automatic logic ref_det(input logic [3:0] v);
      logic [15:0] mask;
      mask = 16'h28AC;
      return mask[v];
   endfunction

   // Modes: 0 correct, 1 all stuck-at-0, 2 out_d flipped at 9, 3 out_b flipped at 15, 4 out_g flipped at 0
   assign out_g = (mode == 1) ? 1'b0 : ((mode == 4 && in_o == 4'd0)  ? ~ref_det(in_o) : ref_det(in_o));
   assign out_d = (mode == 1) ? 1'b0 : ((mode == 2 && in_o == 4'd9)  ? ~ref_det(in_o) : ref_det(in_o));
   assign out_b = (mode == 1) ? 1'b0 : ((mode == 3 && in_o == 4'd15) ? ~ref_det(in_o) : ref_det(in_o));

   typedef struct {
      int m;
      int cycles;
      int exp_pass;
      int exp_fv;
      int exp_err;
      int exp_in;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " in_o"}, in_o, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " pass"}, pass, 0);
      check({tag, " fail_vec"}, fail_vec, 0);
      check({tag, " err_cnt"}, err_cnt, 0);
   endtask

   // Pulses start for one edge, then checks the freshly launched sweep state.
   task automatic start_sweep(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({tag, " launch busy"}, busy, 1);
      check({tag, " launch done"}, done, 0);
      check({tag, " launch in_o"}, in_o, 0);
      check({tag, " launch pass"}, pass, 1);
      check({tag, " launch err_cnt"}, err_cnt, 0);
   endtask

   // Counts edges after launch until done; spot-checks in_o mid-settle of each vector.
   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (!done && n < 4 * SWEEP) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (!done && (n % (S + 1)) == 2) begin
            check($sformatf("%s in_o@%0d", tag, n), in_o, n / (S + 1));
            check($sformatf("%s busy@%0d", tag, n), busy, 1);
         end
      end
      if (!done) check({tag, " timeout done"}, done, 1);
   endtask

   initial begin
      int n;
      int hold_in;

`ifdef SWEEP_ERRCOUNT_EN
      vecs[0] = '{0, SWEEP, 1, 0,  0, 15};
      vecs[1] = '{1, SWEEP, 0, 2,  6, 15};
      vecs[2] = '{2, SWEEP, 0, 9,  1, 15};
      vecs[3] = '{3, SWEEP, 0, 15, 1, 15};
      vecs[4] = '{4, SWEEP, 0, 0,  1, 15};
`else
      vecs[0] = '{0, SWEEP, 1, 0,  0, 15};
      vecs[1] = '{1, 15,    0, 2,  0, 2};
      vecs[2] = '{2, 50,    0, 9,  0, 9};
      vecs[3] = '{3, SWEEP, 0, 15, 0, 15};
      vecs[4] = '{4, 5,     0, 0,  0, 0};
`endif

      mode  = 0;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle("idle hold");

      for (int i = 0; i < 5; i++) begin
         string tag;
         tag  = $sformatf("vec%0d", i);
         mode = vecs[i].m;
         start_sweep(tag);
         wait_done(tag, n);
         check({tag, " cycles"},   n,        vecs[i].cycles);
         check({tag, " done"},     done,     1);
         check({tag, " busy"},     busy,     0);
         check({tag, " pass"},     pass,     vecs[i].exp_pass);
         check({tag, " fail_vec"}, fail_vec, vecs[i].exp_fv);
         check({tag, " err_cnt"},  err_cnt,  vecs[i].exp_err);
         check({tag, " in_o"},     in_o,     vecs[i].exp_in);
      end

      // DONE must hold its results while start stays low.
      hold_in = in_o;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("hold done",     done,     1);
      check("hold in_o",     in_o,     hold_in);
      check("hold pass",     pass,     vecs[4].exp_pass);
      check("hold fail_vec", fail_vec, vecs[4].exp_fv);

      // Reset at edge k+30 aborts the sweep.
      mode = 0;
      start_sweep("abort");
      repeat (29) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle("abort");
      start_sweep("restart");
      wait_done("restart", n);
      check("restart cycles", n, SWEEP);
      check("restart pass",   pass, 1);
      check("restart in_o",   in_o, 15);

      // start held high across a whole sweep: no restart until DONE.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("held launch busy", busy, 1);
      check("held launch in_o", in_o, 0);
      wait_done("held", n);
      check("held cycles", n, SWEEP);
      check("held pass",   pass, 1);
      @(posedge clk);
      @(negedge clk);
      check("held relaunch busy", busy, 1);
      check("held relaunch done", done, 0);
      check("held relaunch in_o", in_o, 0);
      check("held relaunch pass", pass, 1);
      start = 1'b0;

      // rst wins over start on the same edge, even from DONE.
      wait_done("prio", n);
      check("prio reach done", done, 1);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check_idle("prio");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multiples_sweep_checker.md
MULTIPLES_SWEEP_CHECKER -- requirements
Module: multiples_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning wait cycles per vector before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  sweep request; sampled only in IDLE or DONE.
REQ-005 SHALL have port in_o  output  4  vector driven to the three detector instances' in.
REQ-006 SHALL have ports out_g, out_d, out_b  input  1 each  responses of the three detector implementations.
REQ-007 SHALL have port busy  output  1  high while a sweep is in progress (SETTLE or CHECK).
REQ-008 SHALL have port done  output  1  high in DONE; pass and fail_vec valid only while done=1.
REQ-009 SHALL have port pass  output  1  1 = all checked vectors matched.
REQ-010 SHALL have port fail_vec  output  4  first failing vector; 0 when pass=1.
REQ-011 SHALL have port err_cnt  output  5  number of failing vectors (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-013 Golden set SHALL be {2,3,5,7,11,13}; expected=1 for these vectors, 0 otherwise.
REQ-014 A vector SHALL match only if expected=1 and out_g=out_d=out_b=1, or expected=0 and out_g=out_d=out_b=0; any disagreement among the three is a mismatch.
REQ-015 IDLE/DONE with start=1 at edge k: after edge k SHALL be in SETTLE, in_o=0, settle counter cleared, pass=1, fail_vec=0, err_cnt=0, done=0.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles with in_o held, then enter CHECK.
REQ-017 CHECK SHALL last one cycle and compare the sampled responses against golden for in_o.
REQ-018 On first mismatch SHALL set pass=0 and capture fail_vec=in_o; later mismatches SHALL NOT overwrite fail_vec.
REQ-019 From CHECK with in_o<15 and sweep continuing: SHALL increment in_o by 1 and enter SETTLE; with in_o=15: enter DONE.
REQ-020 Full sweep SHALL take 16*(SETTLE_CYCLES+1) cycles; done SHALL rise after edge k+16*(SETTLE_CYCLES+1).
REQ-021 in_o SHALL never wrap to 0 within a sweep; increment from 15 is not performed.
REQ-022 start during SETTLE/CHECK SHALL be ignored.
REQ-023 DONE SHALL hold in_o, pass, fail_vec, err_cnt, done=1 until start or rst.
REQ-024 busy SHALL equal (state==SETTLE or state==CHECK); done SHALL equal (state==DONE).

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, in_o=0, busy=0, done=0, pass=0, fail_vec=0, err_cnt=0, settle counter=0, aborting any sweep.
REQ-026 rst SHALL take priority over start at the same edge.

Configuration
REQ-027 Macro SWEEP_ERRCOUNT_EN SHALL select the error policy.
REQ-028 Defined: sweep SHALL always cover all 16 vectors; err_cnt SHALL increment by 1 per mismatching CHECK (max 16, no saturation needed).
REQ-029 Undefined: first mismatch SHALL enter DONE directly from CHECK; err_cnt SHALL be constant 0 and its counter logic absent.

Verification (SETTLE_CYCLES=4, start pulsed one cycle at edge k)
REQ-030 Correct detectors -> done=1 after edge k+80, pass=1, fail_vec=0, err_cnt=0, in_o=15.
REQ-031 All detectors stuck-at-0, macro undefined -> done after edge k+15, pass=0, fail_vec=2, err_cnt=0.
REQ-032 All stuck-at-0, macro defined -> done after edge k+80, pass=0, fail_vec=2, err_cnt=6.
REQ-033 out_d alone inverted for vector 9 only, macro defined -> pass=0, fail_vec=9, err_cnt=1.
REQ-034 rst pulsed at edge k+30 -> IDLE, busy=0, in_o=0, outputs zero; new start gives full 80-cycle sweep.
REQ-035 start held high throughout sweep -> single sweep, no restart until DONE; in DONE with start=1 a new sweep begins next edge.
